// File: rtl/cnt_seq.sv
// Sequencer for a downstream 4-bit reversible counter: loads a clamped preset and
// bounces the count between lo and hi. Optional window check: CNT_SEQ_WIN_CHK_EN.
module cnt_seq (
    input  logic       cp,
    input  logic       cr,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic [3:0] preset,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] cycles,
    input  logic [3:0] q_in,
    output logic       ct_,
    output logic       ld_,
    output logic       mode,
    output logic [3:0] D,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] turns
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state;
    logic       dir_r;
    logic       mode_r;
    logic [3:0] lo_r;
    logic [3:0] hi_r;
    logic [3:0] cyc_r;

    logic       hit;
    logic       last_hit;
    logic       win_bad;

    // ct_ and mode react to q_in within the RUN cycle; stop masks a bound hit
    always_comb begin
        hit      = (state == RUN) && !stop && (dir_r ? (q_in == lo_r) : (q_in == hi_r));
        last_hit = hit && (cyc_r != '0) && (({1'b0, turns} + 5'd1) == {1'b0, cyc_r});
`ifdef CNT_SEQ_WIN_CHK_EN
        win_bad  = (state == RUN) && !stop && ((q_in < lo_r) || (q_in > hi_r));
`else
        win_bad  = 1'b0;
`endif
        ct_  = !((state == RUN) && !stop && !last_hit && !win_bad);
        mode = (state == RUN) ? (dir_r ^ hit) : mode_r;
        ld_  = (state != LOAD);
        busy = (state == LOAD) || (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge cp or posedge cr) begin
        if (cr) begin
            state  <= IDLE;
            dir_r  <= 1'b0;
            mode_r <= 1'b0;
            lo_r   <= '0;
            hi_r   <= '0;
            cyc_r  <= '0;
            D      <= '0;
            err    <= 1'b0;
            turns  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo < hi) begin
                            lo_r  <= lo;
                            hi_r  <= hi;
                            cyc_r <= cycles;
                            dir_r <= dir;
                            D     <= (preset < lo) ? lo : ((preset > hi) ? hi : preset);
                            turns <= '0;
                            err   <= 1'b0;
                            state <= LOAD;
                        end else begin
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    mode_r <= mode;
                    if (stop) begin
                        state <= IDLE;
                    end else if (win_bad) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else if (hit) begin
                        dir_r <= ~dir_r;
                        if ((cyc_r != '0) || (turns != 4'hF))
                            turns <= turns + 4'd1;
                        if (last_hit)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_seq.sv
// Bench for cnt_seq: a behavioural downstream counter closes the loop, and expected
// trajectories are computed from the bounce rules with plain arithmetic.
module tb_cnt_seq;

    logic       cp;
    logic       cr;
    logic       start;
    logic       stop;
    logic       dir;
    logic [3:0] preset;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] cycles;
    logic [3:0] q_in;
    logic       ct_;
    logic       ld_;
    logic       mode;
    logic [3:0] D;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] turns;

    logic [3:0] cnt_q = '0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;

    int checks = 0;
    int errors = 0;
    int exp_d  = 0;

    cnt_seq dut (
        .cp(cp), .cr(cr), .start(start), .stop(stop), .dir(dir),
        .preset(preset), .lo(lo), .hi(hi), .cycles(cycles), .q_in(q_in),
        .ct_(ct_), .ld_(ld_), .mode(mode), .D(D),
        .busy(busy), .done(done), .err(err), .turns(turns)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    // downstream reversible counter: synchronous load, enable active low
    always @(posedge cp) begin
        if (!ld_)
            cnt_q <= D;
        else if (!ct_)
            cnt_q <= mode ? cnt_q - 4'd1 : cnt_q + 4'd1;
    end

    assign q_in = force_en ? force_val : cnt_q;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int clamp(input int p, input int l, input int h);
        if (p < l) return l;
        if (p > h) return h;
        return p;
    endfunction

    // full bounded sequence; called and returns just after a falling edge
    task automatic run_seq(input int p, input int l, input int h, input int c, input int d);
        int exp_q[$];
        int exp_m[$];
        int exp_ct[$];
        int q;
        int md;
        int t;
        int fin;
        int bound;
        q   = clamp(p, l, h);
        md  = d;
        t   = 0;
        fin = 0;
        for (int i = 0; i < 200 && fin == 0; i++) begin
            bound = ((md == 0 && q == h) || (md == 1 && q == l)) ? 1 : 0;
            if (bound != 0) begin
                t++;
                md = 1 - md;
                if (c != 0 && t == c) fin = 1;
            end
            exp_q.push_back(q);
            exp_m.push_back(md);
            exp_ct.push_back(fin);
            if (fin == 0) q = (md != 0) ? q - 1 : q + 1;
        end
        exp_d  = clamp(p, l, h);
        preset = 4'(p);
        lo     = 4'(l);
        hi     = 4'(h);
        cycles = 4'(c);
        dir    = d[0];
        start  = 1'b1;
        @(posedge cp);
        @(negedge cp);
        start = 1'b0;
        check("load_ld", 8'(ld_), 8'd0);
        check("load_ct", 8'(ct_), 8'd1);
        check("load_busy", 8'(busy), 8'd1);
        check("load_D", 8'(D), 8'(exp_d));
        @(negedge cp);
        foreach (exp_q[i]) begin
            check($sformatf("run_q[%0d]", i), 8'(q_in), 8'(exp_q[i]));
            check($sformatf("run_mode[%0d]", i), 8'(mode), 8'(exp_m[i]));
            check($sformatf("run_ct[%0d]", i), 8'(ct_), 8'(exp_ct[i]));
            check("run_done", 8'(done), 8'd0);
            @(negedge cp);
        end
        check("done_pulse", 8'(done), 8'd1);
        check("done_ct", 8'(ct_), 8'd1);
        check("done_busy", 8'(busy), 8'd0);
        check("done_turns", 8'(turns), 8'(t));
        check("done_err", 8'(err), 8'd0);
        check("done_hold_q", 8'(q_in), 8'(exp_q[exp_q.size()-1]));
        @(negedge cp);
        check("idle_done", 8'(done), 8'd0);
        check("idle_hold_q", 8'(q_in), 8'(exp_q[exp_q.size()-1]));
    endtask

    // unlimited sequence aborted by stop after n RUN cycles
    task automatic run_stop(input int p, input int l, input int h, input int d, input int n);
        int exp_q[$];
        int q;
        int md;
        int t;
        q  = clamp(p, l, h);
        md = d;
        t  = 0;
        for (int i = 0; i <= n; i++) begin
            exp_q.push_back(q);
            if (i < n) begin
                if ((md == 0 && q == h) || (md == 1 && q == l)) begin
                    t++;
                    md = 1 - md;
                end
                q = (md != 0) ? q - 1 : q + 1;
            end
        end
        if (t > 15) t = 15;
        exp_d  = clamp(p, l, h);
        preset = 4'(p);
        lo     = 4'(l);
        hi     = 4'(h);
        cycles = 4'd0;
        dir    = d[0];
        start  = 1'b1;
        @(posedge cp);
        @(negedge cp);
        start = 1'b0;
        @(negedge cp);
        for (int i = 0; i < n; i++) begin
            check($sformatf("stop_run_q[%0d]", i), 8'(q_in), 8'(exp_q[i]));
            @(negedge cp);
        end
        stop = 1'b1;
        #1;
        check("stop_ct", 8'(ct_), 8'd1);
        check("stop_q", 8'(q_in), 8'(exp_q[n]));
        @(negedge cp);
        stop = 1'b0;
        check("stop_busy", 8'(busy), 8'd0);
        check("stop_done", 8'(done), 8'd0);
        check("stop_ld", 8'(ld_), 8'd1);
        check("stop_turns", 8'(turns), 8'(t));
        @(negedge cp);
        check("stop_no_done", 8'(done), 8'd0);
        check("stop_hold_q", 8'(q_in), 8'(exp_q[n]));
    endtask

    initial begin
        int l;
        int h;
        cr = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        preset = '0; lo = '0; hi = '0; cycles = '0;
        @(posedge cp);
        @(negedge cp);
        check("rst_ct", 8'(ct_), 8'd1);
        check("rst_ld", 8'(ld_), 8'd1);
        check("rst_mode", 8'(mode), 8'd0);
        check("rst_D", 8'(D), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_err", 8'(err), 8'd0);
        check("rst_turns", 8'(turns), 8'd0);
        cr = 1'b0;

        run_seq(3, 2, 5, 2, 0);
        run_seq(9, 2, 5, 1, 0);

        // degenerate window: error without load
        lo = 4'd6; hi = 4'd6; preset = 4'd1; cycles = 4'd1; start = 1'b1;
        @(posedge cp);
        @(negedge cp);
        start = 1'b0;
        check("err_set", 8'(err), 8'd1);
        check("err_done", 8'(done), 8'd1);
        check("err_ld", 8'(ld_), 8'd1);
        check("err_busy", 8'(busy), 8'd0);
        check("err_D", 8'(D), 8'(exp_d));
        @(negedge cp);
        check("err_done_once", 8'(done), 8'd0);
        check("err_sticky", 8'(err), 8'd1);
        check("err_busy2", 8'(busy), 8'd0);

        run_seq(0, 4, 9, 1, 1);

        for (int k = 0; k < 8; k++) begin
            l = $urandom_range(0, 13);
            h = $urandom_range(l + 1, 15);
            run_seq($urandom_range(0, 15), l, h, $urandom_range(1, 3), $urandom_range(0, 1));
        end

        run_stop(2, 2, 3, 0, 20);
        l = $urandom_range(0, 10);
        h = $urandom_range(l + 1, 15);
        run_stop($urandom_range(0, 15), l, h, $urandom_range(0, 1), 20);

        // asynchronous reset in the middle of RUN
        preset = 4'd4; lo = 4'd2; hi = 4'd5; cycles = 4'd0; dir = 1'b1; start = 1'b1;
        @(posedge cp);
        @(negedge cp);
        start = 1'b0;
        @(negedge cp);
        check("mid_q", 8'(q_in), 8'd4);
        check("mid_mode", 8'(mode), 8'd1);
        check("mid_busy", 8'(busy), 8'd1);
        #2 cr = 1'b1;
        #1;
        check("arst_ct", 8'(ct_), 8'd1);
        check("arst_ld", 8'(ld_), 8'd1);
        check("arst_mode", 8'(mode), 8'd0);
        check("arst_D", 8'(D), 8'd0);
        check("arst_busy", 8'(busy), 8'd0);
        check("arst_done", 8'(done), 8'd0);
        check("arst_err", 8'(err), 8'd0);
        check("arst_turns", 8'(turns), 8'd0);
        @(negedge cp);
        cr = 1'b0;
        run_seq(3, 2, 5, 1, 0);

        // out-of-window feedback during RUN
        preset = 4'd3; lo = 4'd2; hi = 4'd5; cycles = 4'd0; dir = 1'b0; start = 1'b1;
        @(posedge cp);
        @(negedge cp);
        start = 1'b0;
        @(negedge cp);
        force_val = 4'd7;
        force_en  = 1'b1;
        #1;
`ifdef CNT_SEQ_WIN_CHK_EN
        check("win_ct", 8'(ct_), 8'd1);
        @(negedge cp);
        force_en = 1'b0;
        check("win_err", 8'(err), 8'd1);
        check("win_done", 8'(done), 8'd1);
        check("win_busy", 8'(busy), 8'd0);
        @(negedge cp);
        check("win_done_once", 8'(done), 8'd0);
`else
        check("nowin_ct", 8'(ct_), 8'd0);
        @(negedge cp);
        force_en = 1'b0;
        check("nowin_err", 8'(err), 8'd0);
        check("nowin_busy", 8'(busy), 8'd1);
        stop = 1'b1;
        @(negedge cp);
        stop = 1'b0;
        check("nowin_stop_busy", 8'(busy), 8'd0);
        check("nowin_stop_err", 8'(err), 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
